pspin_dma_rd_desc_arb: RTL

Round-robin arbiter and tag remapper that lets several PsPIN host-memory read requesters share the single read-descriptor port of the PCIe DMA interface. It sits between the requesters and the DMA interface. The requesters are typically multiple `pspin_hostmem_dma_rd`-style datapaths. The block does three things:
- Grants one descriptor per cycle.
- Replaces each requester's tag with an internal slot index so that completions can be routed back.
- Returns each completion status to its originating port with the original tag restored.

---
 rtl/pspin_dma_rd_desc_arb.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pspin_dma_rd_desc_arb.sv
// Round-robin share of one DMA read-descriptor port; requester tags swapped for slot indices and restored on status.
// Latency: grant -> m-side valid 1 cycle; status in -> per-port status out 1 cycle. Stalls while table full or m-side held.
module pspin_dma_rd_desc_arb #(
    parameter int PORTS          = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int RAM_SEL_WIDTH  = 4,
    parameter int RAM_ADDR_WIDTH = 20,
    parameter int DMA_LEN_WIDTH  = 16,
    parameter int S_TAG_WIDTH    = 8,
    parameter int OUTSTANDING    = 8,
    parameter int M_TAG_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [PORTS*ADDR_WIDTH-1:0]        s_axis_read_desc_dma_addr,
    input  logic [PORTS*RAM_SEL_WIDTH-1:0]     s_axis_read_desc_ram_sel,
    input  logic [PORTS*RAM_ADDR_WIDTH-1:0]    s_axis_read_desc_ram_addr,
    input  logic [PORTS*DMA_LEN_WIDTH-1:0]     s_axis_read_desc_len,
    input  logic [PORTS*S_TAG_WIDTH-1:0]       s_axis_read_desc_tag,
    input  logic [PORTS-1:0]                   s_axis_read_desc_valid,
    output logic [PORTS-1:0]                   s_axis_read_desc_ready,
    output logic [ADDR_WIDTH-1:0]              m_axis_read_desc_dma_addr,
    output logic [RAM_SEL_WIDTH-1:0]           m_axis_read_desc_ram_sel,
    output logic [RAM_ADDR_WIDTH-1:0]          m_axis_read_desc_ram_addr,
    output logic [DMA_LEN_WIDTH-1:0]           m_axis_read_desc_len,
    output logic [M_TAG_WIDTH-1:0]             m_axis_read_desc_tag,
    output logic                               m_axis_read_desc_valid,
    input  logic                               m_axis_read_desc_ready,
    input  logic [M_TAG_WIDTH-1:0]             s_axis_read_desc_status_tag,
    input  logic [3:0]                         s_axis_read_desc_status_error,
    input  logic                               s_axis_read_desc_status_valid,
    output logic [PORTS*S_TAG_WIDTH-1:0]       m_axis_read_desc_status_tag,
    output logic [PORTS*4-1:0]                 m_axis_read_desc_status_error,
    output logic [PORTS-1:0]                   m_axis_read_desc_status_valid,
    output logic [$clog2(OUTSTANDING):0]       outstanding_count,
    output logic                               status_unmatched
);

    localparam int SLOT_W = $clog2(OUTSTANDING);
    localparam int CNT_W  = SLOT_W + 1;
    localparam int PTR_W  = $clog2(PORTS);

    if (M_TAG_WIDTH < SLOT_W) begin : g_bad_tag_width
        $error("M_TAG_WIDTH is too narrow to carry a slot index");
    end

    logic [OUTSTANDING-1:0]    tbl_vld_q, tbl_vld_d;
    logic [PTR_W-1:0]          tbl_port_q [OUTSTANDING];
    logic [PTR_W-1:0]          tbl_port_d [OUTSTANDING];
    logic [S_TAG_WIDTH-1:0]    tbl_tag_q  [OUTSTANDING];
    logic [S_TAG_WIDTH-1:0]    tbl_tag_d  [OUTSTANDING];
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic                      m_vld_q, m_vld_d;
    logic [SLOT_W-1:0]         m_tag_q, m_tag_d;
    logic [ADDR_WIDTH-1:0]     m_addr_q, m_addr_d;
    logic [RAM_SEL_WIDTH-1:0]  m_sel_q, m_sel_d;
    logic [RAM_ADDR_WIDTH-1:0] m_raddr_q, m_raddr_d;
    logic [DMA_LEN_WIDTH-1:0]  m_len_q, m_len_d;
    logic [PORTS-1:0]          st_vld_q, st_vld_d;
    logic [PORTS*S_TAG_WIDTH-1:0] st_tag_q, st_tag_d;
    logic [PORTS*4-1:0]        st_err_q, st_err_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      unm_q, unm_d;

    logic                      tbl_full, can_issue, found, grant;
    logic                      st_upper, st_hit, st_miss;
    logic [SLOT_W-1:0]         free_slot, st_slot;
    logic [PTR_W-1:0]          winner, cand, hit_port;

    if (M_TAG_WIDTH > SLOT_W) begin : g_upper
        assign st_upper = |s_axis_read_desc_status_tag[M_TAG_WIDTH-1:SLOT_W];
    end else begin : g_no_upper
        assign st_upper = 1'b0;
    end

    assign st_slot  = s_axis_read_desc_status_tag[SLOT_W-1:0];
    assign hit_port = tbl_port_q[st_slot];
    assign st_hit   = s_axis_read_desc_status_valid && !st_upper && tbl_vld_q[st_slot];
    assign st_miss  = s_axis_read_desc_status_valid && !st_hit;

    // Free slot and full flag use pre-status state, so a slot freed this cycle is reusable only next cycle.
    always_comb begin
        tbl_full  = &tbl_vld_q;
        free_slot = '0;
        for (int i = OUTSTANDING - 1; i >= 0; i--) begin
            if (!tbl_vld_q[i]) free_slot = SLOT_W'(i);
        end
        can_issue = !tbl_full && (!m_vld_q || m_axis_read_desc_ready);
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < PORTS; k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % PORTS);
            if (!found && s_axis_read_desc_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        grant = can_issue && found;
        s_axis_read_desc_ready = '0;
        if (grant) s_axis_read_desc_ready[winner] = 1'b1;
    end

    always_comb begin
        tbl_vld_d  = tbl_vld_q;
        tbl_port_d = tbl_port_q;
        tbl_tag_d  = tbl_tag_q;
        rr_ptr_d   = rr_ptr_q;
        m_vld_d    = m_vld_q;
        m_tag_d    = m_tag_q;
        m_addr_d   = m_addr_q;
        m_sel_d    = m_sel_q;
        m_raddr_d  = m_raddr_q;
        m_len_d    = m_len_q;
        st_vld_d   = '0;
        st_tag_d   = st_tag_q;
        st_err_d   = st_err_q;
        count_d    = count_q + CNT_W'(grant) - CNT_W'(st_hit);
        unm_d      = unm_q | st_miss;

        if (st_hit) begin
            tbl_vld_d[st_slot] = 1'b0;
            st_vld_d[hit_port] = 1'b1;
            st_tag_d[hit_port*S_TAG_WIDTH +: S_TAG_WIDTH] = tbl_tag_q[st_slot];
            st_err_d[hit_port*4 +: 4] = s_axis_read_desc_status_error;
        end

        if (grant) begin
            tbl_vld_d[free_slot]  = 1'b1;
            tbl_port_d[free_slot] = winner;
            tbl_tag_d[free_slot]  = s_axis_read_desc_tag[winner*S_TAG_WIDTH +: S_TAG_WIDTH];
            rr_ptr_d  = PTR_W'((int'(winner) + 1) % PORTS);
            m_vld_d   = 1'b1;
            m_tag_d   = free_slot;
            m_addr_d  = s_axis_read_desc_dma_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
            m_sel_d   = s_axis_read_desc_ram_sel[winner*RAM_SEL_WIDTH +: RAM_SEL_WIDTH];
            m_raddr_d = s_axis_read_desc_ram_addr[winner*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            m_len_d   = s_axis_read_desc_len[winner*DMA_LEN_WIDTH +: DMA_LEN_WIDTH];
        end else if (m_axis_read_desc_ready) begin
            m_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_vld_q <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                tbl_port_q[i] <= '0;
                tbl_tag_q[i]  <= '0;
            end
            rr_ptr_q  <= '0;
            m_vld_q   <= 1'b0;
            m_tag_q   <= '0;
            m_addr_q  <= '0;
            m_sel_q   <= '0;
            m_raddr_q <= '0;
            m_len_q   <= '0;
            st_vld_q  <= '0;
            st_tag_q  <= '0;
            st_err_q  <= '0;
            count_q   <= '0;
            unm_q     <= 1'b0;
        end else begin
            tbl_vld_q  <= tbl_vld_d;
            tbl_port_q <= tbl_port_d;
            tbl_tag_q  <= tbl_tag_d;
            rr_ptr_q   <= rr_ptr_d;
            m_vld_q    <= m_vld_d;
            m_tag_q    <= m_tag_d;
            m_addr_q   <= m_addr_d;
            m_sel_q    <= m_sel_d;
            m_raddr_q  <= m_raddr_d;
            m_len_q    <= m_len_d;
            st_vld_q   <= st_vld_d;
            st_tag_q   <= st_tag_d;
            st_err_q   <= st_err_d;
            count_q    <= count_d;
            unm_q      <= unm_d;
        end
    end

    assign m_axis_read_desc_valid        = m_vld_q;
    assign m_axis_read_desc_tag          = M_TAG_WIDTH'(m_tag_q);
    assign m_axis_read_desc_dma_addr     = m_addr_q;
    assign m_axis_read_desc_ram_sel      = m_sel_q;
    assign m_axis_read_desc_ram_addr     = m_raddr_q;
    assign m_axis_read_desc_len          = m_len_q;
    assign m_axis_read_desc_status_valid = st_vld_q;
    assign m_axis_read_desc_status_tag   = st_tag_q;
    assign m_axis_read_desc_status_error = st_err_q;
    assign outstanding_count             = count_q;
    assign status_unmatched              = unm_q;

endmodule
